mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/cpu_pkg.sv | 17 +
 rtl/mem_bus_arbiter_rr_pick.sv | 14 +
 rtl/mem_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory bus arbiter: FSM states, access
// direction constants and the default ISSUE timeout.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int TIMEOUT_DEFAULT = 15;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Two-way round-robin selector: on a tie the port that was not granted
// last wins; a lone request always wins.
module rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic win,
  output logic valid
);

  assign valid = req0 | req1;
  assign win   = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single memory bus with
// round-robin fairness, registered outputs and an ISSUE-phase timeout.
module mem_bus_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_rw,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_rw,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t               state_reg, state_next;
  logic                     win_reg, win_next;
  logic                     last_reg, last_next;
  logic                     rw_reg, rw_next;
  logic                     mem_req_reg, mem_req_next;
  logic [ADDR_W-1:0]        addr_reg, addr_next;
  logic [DATA_W-1:0]        wdata_reg, wdata_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic [1:0]               gnt_reg, gnt_next;
  logic [1:0]               done_reg, done_next;
  logic [1:0]               err_reg, err_next;
  logic [1:0][DATA_W-1:0]   rdata_reg;
  logic [1:0]               rdata_load;

  logic pick_win, pick_valid;

  rr_pick u_rr_pick (
    .req0  (p0_req),
    .req1  (p1_req),
    .last  (last_reg),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      win_reg     <= 1'b0;
      last_reg    <= 1'b1;
      rw_reg      <= RW_READ;
      mem_req_reg <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      cnt_reg     <= '0;
      gnt_reg     <= '0;
      done_reg    <= '0;
      err_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      win_reg     <= win_next;
      last_reg    <= last_next;
      rw_reg      <= rw_next;
      mem_req_reg <= mem_req_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      cnt_reg     <= cnt_next;
      gnt_reg     <= gnt_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    win_next     = win_reg;
    last_next    = last_reg;
    rw_next      = rw_reg;
    mem_req_next = mem_req_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    cnt_next     = cnt_reg;
    gnt_next     = '0;
    done_next    = '0;
    err_next     = '0;
    rdata_load   = '0;

    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          win_next           = pick_win;
          rw_next            = pick_win ? p1_rw    : p0_rw;
          addr_next          = pick_win ? p1_addr  : p0_addr;
          wdata_next         = pick_win ? p1_wdata : p0_wdata;
          mem_req_next       = 1'b1;
          gnt_next[pick_win] = 1'b1;
          cnt_next           = '0;
          state_next         = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A ready on the final allowed cycle still counts as a good completion.
        if (mem_ready) begin
          rdata_load[win_reg] = (rw_reg == RW_READ);
          mem_req_next        = 1'b0;
          done_next[win_reg]  = 1'b1;
          state_next          = ST_RESP;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          mem_req_next        = 1'b0;
          done_next[win_reg]  = 1'b1;
          err_next[win_reg]   = 1'b1;
          state_next          = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RESP: begin
        last_next  = win_reg;
        state_next = ST_IDLE;
      end
      default: begin
        state_next   = ST_IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  // Per-port read data holds until that port's next read completion.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        rdata_reg[gi] <= '0;
      else if (rdata_load[gi])
        rdata_reg[gi] <= mem_rdata;
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_rw    = rw_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign p0_gnt    = gnt_reg[0];
  assign p1_gnt    = gnt_reg[1];
  assign p0_done   = done_reg[0];
  assign p1_done   = done_reg[1];
  assign p0_err    = err_reg[0];
  assign p1_err    = err_reg[1];
  assign p0_rdata  = rdata_reg[0];
  assign p1_rdata  = rdata_reg[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: grant/done timing,
// round-robin alternation, timeout, async reset abort and rdata holding.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        p0_req = 1'b0, p0_rw = 1'b0;
  logic [63:0] p0_addr = '0, p0_wdata = '0;
  logic        p0_gnt, p0_done, p0_err;
  logic [63:0] p0_rdata;
  logic        p1_req = 1'b0, p1_rw = 1'b0;
  logic [63:0] p1_addr = '0, p1_wdata = '0;
  logic        p1_gnt, p1_done, p1_err;
  logic [63:0] p1_rdata;
  logic        mem_req, mem_rw;
  logic [63:0] mem_addr, mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++;
    if ({mem_req, mem_rw, p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err} !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {mem_req, mem_rw, p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, p0_rdata, p1_rdata} !== 256'h0) begin
      fails++;
      $display("FAIL reset_data: addr=%h wdata=%h r0=%h r1=%h expected all 0",
               mem_addr, mem_wdata, p0_rdata, p1_rdata);
    end
    reset = 1'b1;
    step();
    $display("reset: outputs cleared");
  endtask

  task automatic test_round_robin();
    logic exp_port;
    p0_rw = 1'b0; p0_addr = 64'h10;
    p1_rw = 1'b0; p1_addr = 64'h20;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_port = i[0];
      step();
      checks++;
      if ({p1_gnt, p0_gnt} !== (exp_port ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL rr_gnt[%0d]: got %b expected %b", i, {p1_gnt, p0_gnt},
                 exp_port ? 2'b10 : 2'b01);
      end
      checks++;
      if (mem_addr !== (exp_port ? 64'h20 : 64'h10)) begin
        fails++;
        $display("FAIL rr_addr[%0d]: got %h expected %h", i, mem_addr,
                 exp_port ? 64'h20 : 64'h10);
      end
      if (exp_port) p1_req = 1'b0; else p0_req = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 64'h1000 + 64'(i);
      step();
      checks++;
      if ({p1_done, p0_done} !== (exp_port ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL rr_done[%0d]: got %b expected %b", i, {p1_done, p0_done},
                 exp_port ? 2'b10 : 2'b01);
      end
      mem_ready = 1'b0;
      if (i < 3) begin
        p0_req = 1'b1; p1_req = 1'b1;
      end
      step();
      $display("round_robin: transaction %0d granted port %0d", i, exp_port);
    end
  endtask

  task automatic test_single_read();
    p0_rw = 1'b0; p0_addr = 64'h100; p0_req = 1'b1;
    step();
    checks++;
    if ({p0_gnt, p1_gnt, mem_req, mem_rw} !== 4'b1010 || mem_addr !== 64'h100) begin
      fails++;
      $display("FAIL single_gnt: gnt0=%b gnt1=%b req=%b rw=%b addr=%h expected 1 0 1 0 100",
               p0_gnt, p1_gnt, mem_req, mem_rw, mem_addr);
    end
    p0_req = 1'b0;
    mem_ready = 1'b1; mem_rdata = 64'hDEAD;
    step();
    mem_ready = 1'b0;
    checks++;
    if ({p0_done, p0_err, p0_gnt, mem_req} !== 4'b1000 || p0_rdata !== 64'hDEAD) begin
      fails++;
      $display("FAIL single_done: done=%b err=%b gnt=%b req=%b rdata=%h expected 1 0 0 0 dead",
               p0_done, p0_err, p0_gnt, mem_req, p0_rdata);
    end
    step();
    checks++;
    if (p0_done !== 1'b0) begin
      fails++;
      $display("FAIL single_done_pulse: done=%b expected 0", p0_done);
    end
    $display("single_read: p0 read 0x100 rdata=%h", p0_rdata);
  endtask

  task automatic test_timeout();
    int high_cycles;
    p1_rw = 1'b1; p1_addr = 64'h200; p1_wdata = 64'h55; p1_req = 1'b1;
    step();
    checks++;
    if ({p1_gnt, mem_req, mem_rw} !== 3'b111 || mem_addr !== 64'h200 || mem_wdata !== 64'h55) begin
      fails++;
      $display("FAIL timeout_gnt: gnt=%b req=%b rw=%b addr=%h wdata=%h expected 1 1 1 200 55",
               p1_gnt, mem_req, mem_rw, mem_addr, mem_wdata);
    end
    p1_req = 1'b0;
    high_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_req) high_cycles++;
      else break;
    end
    checks++;
    if (high_cycles != 15) begin
      fails++;
      $display("FAIL timeout_len: mem_req high %0d cycles expected 15", high_cycles);
    end
    checks++;
    if ({p1_done, p1_err, mem_req} !== 3'b110) begin
      fails++;
      $display("FAIL timeout_err: done=%b err=%b req=%b expected 1 1 0", p1_done, p1_err, mem_req);
    end
    step();
    $display("timeout: p1 write errored after %0d cycles", high_cycles);
  endtask

  task automatic test_ready_last_cycle();
    p0_rw = 1'b0; p0_addr = 64'h300; p0_req = 1'b1;
    step();
    p0_req = 1'b0;
    for (int i = 0; i < 14; i++) step();
    checks++;
    if ({mem_req, p0_done} !== 2'b10) begin
      fails++;
      $display("FAIL edge_pending: req=%b done=%b expected 1 0 after 14 ISSUE edges", mem_req, p0_done);
    end
    mem_ready = 1'b1; mem_rdata = 64'hBEEF;
    step();
    mem_ready = 1'b0;
    checks++;
    if ({p0_done, p0_err} !== 2'b10 || p0_rdata !== 64'hBEEF) begin
      fails++;
      $display("FAIL edge_ready: done=%b err=%b rdata=%h expected 1 0 beef", p0_done, p0_err, p0_rdata);
    end
    step();
    $display("ready_last_cycle: p0 rdata=%h", p0_rdata);
  endtask

  task automatic test_reset_abort();
    p1_rw = 1'b0; p1_addr = 64'h400; p1_req = 1'b1;
    step();
    p1_req = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("FAIL abort_async: mem_req=%b expected 0", mem_req);
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    checks++;
    if ({p0_done, p1_done, p0_gnt, p1_gnt} !== 4'b0000) begin
      fails++;
      $display("FAIL abort_done: done=%b%b gnt=%b%b expected 0000", p0_done, p1_done, p0_gnt, p1_gnt);
    end
    reset = 1'b1;
    p0_rw = 1'b0; p0_addr = 64'h500; p0_req = 1'b1; p1_req = 1'b1;
    step();
    checks++;
    if ({p1_gnt, p0_gnt} !== 2'b01) begin
      fails++;
      $display("FAIL abort_tie: gnt=%b expected 01", {p1_gnt, p0_gnt});
    end
    p0_req = 1'b0; p1_req = 1'b0;
    mem_ready = 1'b1; mem_rdata = 64'h11;
    step();
    mem_ready = 1'b0;
    step();
    $display("reset_abort: tie after reset granted p0");
  endtask

  task automatic test_rdata_hold();
    p1_rw = 1'b0; p1_addr = 64'h600; p1_req = 1'b1;
    step();
    p1_req = 1'b0;
    mem_ready = 1'b1; mem_rdata = 64'h77;
    step();
    mem_ready = 1'b0;
    checks++;
    if (p1_rdata !== 64'h77) begin
      fails++;
      $display("FAIL hold_read: p1_rdata=%h expected 77", p1_rdata);
    end
    step();
    p1_rw = 1'b1; p1_addr = 64'h608; p1_wdata = 64'hAA; p1_req = 1'b1;
    step();
    p1_req = 1'b0;
    mem_ready = 1'b1; mem_rdata = 64'h99;
    step();
    mem_ready = 1'b0;
    checks++;
    if (p1_done !== 1'b1 || p1_rdata !== 64'h77 || p0_rdata !== 64'h11) begin
      fails++;
      $display("FAIL hold_write: done=%b p1_rdata=%h p0_rdata=%h expected 1 77 11",
               p1_done, p1_rdata, p0_rdata);
    end
    step();
    mem_ready = 1'b1; mem_rdata = 64'hABC;
    step();
    step();
    mem_ready = 1'b0;
    checks++;
    if ({mem_req, p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err} !== 7'b0 ||
        p0_rdata !== 64'h11 || p1_rdata !== 64'h77) begin
      fails++;
      $display("FAIL spurious_ready: ctrl=%b r0=%h r1=%h expected 0000000 11 77",
               {mem_req, p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err}, p0_rdata, p1_rdata);
    end
    $display("rdata_hold: p1_rdata=%h p0_rdata=%h", p1_rdata, p0_rdata);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_timeout();
    test_ready_last_cycle();
    test_reset_abort();
    test_rdata_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
